tlul_mem_resp: RTL
==================

# tlul_mem_resp

Synthesizable TL-UL device-side responder: a small word-addressed memory that sits directly downstream of the TL-UL host, consuming its A-channel requests and producing D-channel responses. It supports one outstanding transaction with a programmable response latency, byte-masked writes, and error responses for illegal requests. It is the standard target for host read/write bring-up benches and can stand in for a register block during integration.

## Interface
- TL_AW, top_pkg::TL_AW, address width
- TL_DW, 32, data width; only 32 is supported
- DEPTH, 64, number of 32-bit words; power of two, 2..1024
- BASE_ADDR, 32'h0, byte address of word 0; DEPTH*4-aligned
- LATENCY, 0, extra wait cycles before D response; 0..15
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- tl_h2d_i  input  tlul_pkg::tl_h2d_t  A channel plus d_ready from the host
- tl_d2h_o  output  tlul_pkg::tl_d2h_t  D channel plus a_ready to the host
- intg_err_o  output  1  sticky integrity-error flag

## Operation
- FSM states:
  - IDLE: a_ready=1. If a_valid, go to WAIT when LATENCY>0, or to RESP when LATENCY=0.
  - WAIT: a_ready=0. A counter loads LATENCY-1 and decrements. At 0, go to RESP.
  - RESP: d_valid=1, a_ready=0. When d_ready, go to IDLE.
- All request side-effects occur at the acceptance edge:
  - Memory write with byte enables from a_mask.
  - Read data capture. A write followed by a read of the same word returns the new data.
- The response register holds the following fields, stable from the first cycle of d_valid until the handshake:
  - d_opcode: AccessAckData for Get, AccessAck otherwise.
  - d_size and d_source echoed from the request.
  - d_param=0, d_sink=0.
  - d_data: read word for Get, 0 otherwise.
  - d_error, as defined below.
  - d_user=TL_D_USER_DEFAULT.
- Errors:
  - Conditions:
    - Opcode not one of Get, PutFullData, PutPartialData.
    - a_size>2.
    - Address not aligned to 2^a_size.
    - Address outside [BASE_ADDR, BASE_ADDR+DEPTH*4).
    - PutFullData whose a_mask is not exactly the lanes covered by a_size/address.
    - Integrity failure (see Configuration).
  - On any error: d_error=1, d_data=0, and memory is unchanged.
- Word index = (a_address-BASE_ADDR)[log2(DEPTH)+1:2]. There is no wrap: out-of-range addresses are errors.
- intg_err_o sets on any integrity failure and clears only on reset.

## Timing
- Reset values:
  - State IDLE.
  - a_ready=1, d_valid=0.
  - All d_* fields 0 except d_user=TL_D_USER_DEFAULT.
  - intg_err_o=0.
  - Every memory word 0.
- Request accepted at edge k (a_valid&a_ready): d_valid rises in cycle k+1+LATENCY.
- Back-to-back throughput:
  - a_ready returns in the cycle after the D handshake.
  - The maximum rate is one transaction per 2+LATENCY cycles when d_ready is held high.
- d_ready low: d_valid and all d_* fields are held indefinitely. There is no timeout.
- a_valid asserted while a_ready=0 is ignored; the host must hold it.
- Reset mid-transaction:
  - Immediate return to IDLE, response dropped, d_valid=0 asynchronously.
  - Memory is cleared, including any write accepted before reset.
- d_ready is sampled only in RESP; a d_ready pulse in IDLE or WAIT has no effect.

## Configuration
- TLUL_MEM_RESP_INTG_CHK_EN defined:
  - At acceptance, the block recomputes tlul_pkg::get_data_intg(a_data) and tlul_pkg::get_cmd_intg(tl_h2d_i).
  - Either mismatch with a_user makes the transaction an error response and sets intg_err_o.
- Macro undefined:
  - a_user is ignored.
  - intg_err_o is tied to 0.
  - No integrity logic is synthesized.

## Test plan
- Write then read:
  - Stimulus: PutFullData addr=BASE+0x10, data=32'hDEADBEEF, mask=F; then Get at 0x10.
  - Required: AccessAck with d_error=0; then AccessAckData with d_data=32'hDEADBEEF.
- Partial write:
  - Stimulus: with word 0x10=32'hDEADBEEF, PutPartialData data=32'h12345678, mask=4'h3; then Get.
  - Required: d_data=32'hDEAD5678.
- Error cases:
  - Get at BASE+DEPTH*4 → d_error=1, d_data=0.
  - Opcode 3'h5 → d_error=1.
  - Put at addr 0x2 with a_size=2 → d_error=1, and a follow-up Get shows the memory unchanged.
- Latency and backpressure:
  - Stimulus: LATENCY=3, Get accepted at cycle k, d_ready held low for 4 cycles.
  - Required: d_valid rises at k+4, fields stay stable, and a_ready returns the cycle after the handshake.
- Reset mid-response:
  - Stimulus: assert rst_i while d_valid=1.
  - Required: d_valid drops without waiting for clk_i, a_ready=1, and a subsequent Get returns 0.
- Integrity (macro defined):
  - Stimulus: PutFullData with cmd_intg bit 0 flipped.
  - Required: d_error=1, memory unchanged, intg_err_o=1 until reset.
  - Correct integrity gives d_error=0.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL channel structs, opcodes, user defaults and the integrity-code functions.
package tlul_pkg;
    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    parameter tl_d_user_t TL_D_USER_DEFAULT = '{rsp_intg: 7'h7f, data_intg: 7'h7f};

    typedef struct packed {
        logic                        a_valid;
        tl_a_op_e                    a_opcode;
        logic [2:0]                  a_param;
        logic [top_pkg::TL_SZW-1:0]  a_size;
        logic [top_pkg::TL_AIW-1:0]  a_source;
        logic [top_pkg::TL_AW-1:0]   a_address;
        logic [top_pkg::TL_DBW-1:0]  a_mask;
        logic [top_pkg::TL_DW-1:0]   a_data;
        tl_a_user_t                  a_user;
        logic                        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                        d_valid;
        tl_d_op_e                    d_opcode;
        logic [2:0]                  d_param;
        logic [top_pkg::TL_SZW-1:0]  d_size;
        logic [top_pkg::TL_AIW-1:0]  d_source;
        logic [top_pkg::TL_DIW-1:0]  d_sink;
        logic [top_pkg::TL_DW-1:0]   d_data;
        tl_d_user_t                  d_user;
        logic                        d_error;
        logic                        a_ready;
    } tl_d2h_t;

    // Each input bit is folded into code bit (index mod 7).
    function automatic logic [6:0] fold7(input logic [63:0] v);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i % 7] = r[i % 7] ^ v[i];
        end
        return r;
    endfunction

    function automatic logic [6:0] get_data_intg(input logic [top_pkg::TL_DW-1:0] d);
        return fold7({32'h0, d});
    endfunction

    function automatic logic [6:0] get_cmd_intg(input tl_h2d_t t);
        logic unused_fields;
        unused_fields = ^{t.a_valid, t.a_param, t.a_size, t.a_source, t.a_data,
                          t.a_user.cmd_intg, t.a_user.data_intg, t.d_ready};
        return fold7({21'h0, t.a_user.instr_type, t.a_address, t.a_opcode, t.a_mask});
    endfunction
endpackage

// File: rtl/top_pkg.sv
// Global TL-UL bus dimensions shared by all TL-UL packages and blocks.
package top_pkg;
    parameter int TL_AW  = 32;
    parameter int TL_DW  = 32;
    parameter int TL_AIW = 8;
    parameter int TL_DIW = 1;
    parameter int TL_SZW = 2;
    parameter int TL_DBW = TL_DW / 8;
endpackage

// File: rtl/tlul_mem_resp.sv
// TL-UL memory responder, one outstanding request; D valid LATENCY+1 cycles after acceptance, a_ready low
// until the D handshake, D fields held while d_ready low. Optional integrity check: TLUL_MEM_RESP_INTG_CHK_EN.
module tlul_mem_resp
    import tlul_pkg::*;
#(
    parameter int               TL_AW     = top_pkg::TL_AW,
    parameter int               TL_DW     = 32,
    parameter int               DEPTH     = 64,
    parameter logic [TL_AW-1:0] BASE_ADDR = '0,
    parameter int               LATENCY   = 0
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h2d_i,
    output tl_d2h_t tl_d2h_o,
    output logic    intg_err_o
);
    localparam int         IW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e           state, state_nxt;
    logic [3:0]       cnt;
    logic [TL_DW-1:0] mem [DEPTH];
    logic             a_ready, d_valid, accept;
    logic [TL_AW-1:0] offset;
    logic [IW-1:0]    idx;
    logic [3:0]       full_mask;
    logic             is_get, is_full, is_part;
    logic             err_op, err_size, err_align, err_range, err_mask, err_intg, req_err;

    tl_d_op_e                   rsp_opcode;
    logic [top_pkg::TL_SZW-1:0] rsp_size;
    logic [top_pkg::TL_AIW-1:0] rsp_source;
    logic [TL_DW-1:0]           rsp_data;
    logic                       rsp_error;

    assign accept = a_ready && tl_h2d_i.a_valid;
    assign offset = tl_h2d_i.a_address - BASE_ADDR;
    assign idx    = offset[IW+1:2];

    assign is_get  = (tl_h2d_i.a_opcode == Get);
    assign is_full = (tl_h2d_i.a_opcode == PutFullData);
    assign is_part = (tl_h2d_i.a_opcode == PutPartialData);

    // Lanes a PutFullData must enable exactly, given size and byte offset.
    always_comb begin
        full_mask = 4'hf;
        case (tl_h2d_i.a_size)
            2'd0:    full_mask = 4'b0001 << tl_h2d_i.a_address[1:0];
            2'd1:    full_mask = 4'b0011 << tl_h2d_i.a_address[1:0];
            default: full_mask = 4'hf;
        endcase
    end

    assign err_op    = !(is_get || is_full || is_part);
    assign err_size  = (tl_h2d_i.a_size == 2'd3);
    assign err_align = ((tl_h2d_i.a_size == 2'd1) && tl_h2d_i.a_address[0]) ||
                       ((tl_h2d_i.a_size == 2'd2) && (tl_h2d_i.a_address[1:0] != 2'b00));
    assign err_range = (offset[TL_AW-1:IW+2] != '0);
    assign err_mask  = is_full && (tl_h2d_i.a_mask != full_mask);
    assign req_err   = err_op || err_size || err_align || err_range || err_mask || err_intg;

`ifdef TLUL_MEM_RESP_INTG_CHK_EN
    logic intg_err_q;

    assign err_intg = (tl_h2d_i.a_user.cmd_intg  != get_cmd_intg(tl_h2d_i)) ||
                      (tl_h2d_i.a_user.data_intg != get_data_intg(tl_h2d_i.a_data));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            intg_err_q <= 1'b0;
        end else if (accept && err_intg) begin
            intg_err_q <= 1'b1;
        end
    end
    assign intg_err_o = intg_err_q;
`else
    assign err_intg   = 1'b0;
    assign intg_err_o = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{tl_h2d_i.a_param, tl_h2d_i.a_user, offset[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && (is_full || is_part) && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (tl_h2d_i.a_mask[b]) begin
                    mem[idx][8*b +: 8] <= tl_h2d_i.a_data[8*b +: 8];
                end
            end
        end
    end

    // Response fields are captured once at acceptance and held until the handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_opcode <= AccessAck;
            rsp_size   <= '0;
            rsp_source <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
        end else if (accept) begin
            rsp_opcode <= is_get ? AccessAckData : AccessAck;
            rsp_size   <= tl_h2d_i.a_size;
            rsp_source <= tl_h2d_i.a_source;
            rsp_data   <= (is_get && !req_err) ? mem[idx] : '0;
            rsp_error  <= req_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= LAT_M1;
            end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        a_ready   = 1'b0;
        d_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                a_ready = 1'b1;
                if (tl_h2d_i.a_valid) begin
                    state_nxt = (LATENCY > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                d_valid = 1'b1;
                if (tl_h2d_i.d_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tl_d2h_o          = '0;
        tl_d2h_o.d_valid  = d_valid;
        tl_d2h_o.d_opcode = rsp_opcode;
        tl_d2h_o.d_size   = rsp_size;
        tl_d2h_o.d_source = rsp_source;
        tl_d2h_o.d_data   = rsp_data;
        tl_d2h_o.d_error  = rsp_error;
        tl_d2h_o.d_user   = TL_D_USER_DEFAULT;
        tl_d2h_o.a_ready  = a_ready;
    end
endmodule
